// File: rtl/shape_cmd_arbiter.sv
// shape_cmd_arbiter: round-robin sharing of the shape rasterizer between two command requesters.
// Watchdog in WAIT is built only when SHAPE_ARB_TIMEOUT_EN is defined.
module shape_cmd_arbiter #(
  parameter int WORD_W = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic [WORD_W-1:0] op_data,
  output logic              shift_enable,
  output logic              new_shape,
  input  logic              shape_done,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              timeout_err,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;
  state_t state;
  logic [1:0] word_cnt;
  logic last_served, pick1, expired;
  assign req_ready = grant & {2{state == LOAD}};
  assign shift_enable = |(req_valid & req_ready);
  assign op_data = !shift_enable ? '0 : grant[1] ? req_data1 : req_data0;
  assign busy = state != IDLE;
  // on a tie, requester 1 wins only if requester 0 was served last
  assign pick1 = req_valid[1] & (~req_valid[0] | ~last_served);
`ifdef SHAPE_ARB_TIMEOUT_EN
  logic [15:0] wdog;
  assign expired = (state == WAIT) && (wdog == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) wdog <= '0;
    else wdog <= (state == WAIT) ? wdog + 16'd1 : '0;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      word_cnt <= '0;
      last_served <= 1'b1;
      new_shape <= 1'b0;
      done <= '0;
      timeout_err <= 1'b0;
    end else begin
      new_shape <= 1'b0;
      done <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant <= pick1 ? 2'b10 : 2'b01;
          word_cnt <= '0;
          state <= LOAD;
        end
        LOAD: if (shift_enable) begin
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd2) begin
            state <= START;
            new_shape <= 1'b1;
          end
        end
        START: state <= WAIT;
        // a completion arriving together with expiry is a normal completion
        WAIT: if (shape_done || expired) begin
          state <= DONE;
          done <= grant;
          timeout_err <= ~shape_done;
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          last_served <= grant[1];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
